// File: rtl/motoro3_pkg.sv
// Shared encodings for the motoro3 gate driver: leg states/requests, sector codes, step decode.
package motoro3_pkg;

    typedef enum logic [1:0] {
        LEG_OFF = 2'd0,
        LEG_HI  = 2'd1,
        LEG_LO  = 2'd2
    } leg_state_e;

    typedef enum logic [1:0] {
        REQ_OFF = 2'd0,
        REQ_HI  = 2'd1,
        REQ_LO  = 2'd2
    } leg_req_e;

    localparam logic [2:0] SECTOR_0     = 3'd0;
    localparam logic [2:0] SECTOR_1     = 3'd1;
    localparam logic [2:0] SECTOR_2     = 3'd2;
    localparam logic [2:0] SECTOR_3     = 3'd3;
    localparam logic [2:0] SECTOR_4     = 3'd4;
    localparam logic [2:0] SECTOR_5     = 3'd5;
    localparam logic [2:0] SECTOR_COAST = 3'd7;

    // Steps come in pairs per sector; 0 and 13..15 are not valid steps and mean coast.
    function automatic logic [2:0] step_to_sector(input logic [3:0] step);
        logic [2:0] sec;
        case (step)
            4'd1, 4'd2:   sec = SECTOR_0;
            4'd3, 4'd4:   sec = SECTOR_1;
            4'd5, 4'd6:   sec = SECTOR_2;
            4'd7, 4'd8:   sec = SECTOR_3;
            4'd9, 4'd10:  sec = SECTOR_4;
            4'd11, 4'd12: sec = SECTOR_5;
            default:      sec = SECTOR_COAST;
        endcase
        return sec;
    endfunction

endpackage

// File: rtl/motoro3_leg_deadtime.sv
// One half-bridge leg: OFF/HI/LO state machine with a dead-time lockout after every turn-off.
// Gates are decoded from the state register, so H and L can never be high together.
module motoro3_leg_deadtime
    import motoro3_pkg::*;
#(
    parameter int DT_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  leg_req_e        req,
    input  logic [DT_W-1:0] m3r_deadTime,
    output logic            gateH,
    output logic            gateL
);

    leg_state_e      state_q, state_d;
    logic [DT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LEG_OFF;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            LEG_OFF: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - DT_W'(1);
                end else if (req == REQ_HI) begin
                    state_d = LEG_HI;
                end else if (req == REQ_LO) begin
                    state_d = LEG_LO;
                end
            end
            // Any departure from a driven state, including to OFF, passes through a lockout.
            LEG_HI: begin
                if (req != REQ_HI) begin
                    state_d = LEG_OFF;
                    cnt_d   = m3r_deadTime;
                end
            end
            LEG_LO: begin
                if (req != REQ_LO) begin
                    state_d = LEG_OFF;
                    cnt_d   = m3r_deadTime;
                end
            end
            default: begin
                state_d = LEG_OFF;
                cnt_d   = '0;
            end
        endcase
    end

    assign gateH = (state_q == LEG_HI);
    assign gateL = (state_q == LEG_LO);

endmodule

// File: rtl/motoro3_gate_driver.sv
// Six-step gate driver: decodes the commutation step into per-leg requests gated by PWM,
// enable and fault, and drives three dead-time protected legs. Fault input latches.
module motoro3_gate_driver
    import motoro3_pkg::*;
#(
    parameter int DT_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pwm,
    input  logic [3:0]      sgStep,
    input  logic [DT_W-1:0] m3r_deadTime,
    input  logic            m3r_gateEn,
    input  logic            m3r_faultClr,
    input  logic            faultIn,
    output logic            gateAH,
    output logic            gateAL,
    output logic            gateBH,
    output logic            gateBL,
    output logic            gateCH,
    output logic            gateCL,
    output logic            faultLatched,
    output logic [2:0]      sector
);

    logic [2:0] sector_q, sector_d;
    logic       fault_q, fault_d;
    logic       force_off;
    leg_req_e   pwm_req;
    leg_req_e   req_a, req_b, req_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            sector_q <= SECTOR_COAST;
            fault_q  <= 1'b0;
        end else begin
            sector_q <= sector_d;
            fault_q  <= fault_d;
        end
    end

    // A fault present on the same edge as a clear request keeps the latch set.
    always_comb begin
        fault_d = fault_q;
        if (faultIn) begin
            fault_d = 1'b1;
        end else if (m3r_faultClr) begin
            fault_d = 1'b0;
        end
    end

    always_comb begin
        sector_d  = step_to_sector(sgStep);
        force_off = (sector_d == SECTOR_COAST) || !m3r_gateEn || fault_q || faultIn;
        pwm_req   = REQ_OFF;
        if (pwm) begin
            pwm_req = REQ_HI;
        end
        req_a = REQ_OFF;
        req_b = REQ_OFF;
        req_c = REQ_OFF;
        if (!force_off) begin
            case (sector_d)
                SECTOR_0: begin req_a = pwm_req; req_b = REQ_LO; end
                SECTOR_1: begin req_a = pwm_req; req_c = REQ_LO; end
                SECTOR_2: begin req_b = pwm_req; req_c = REQ_LO; end
                SECTOR_3: begin req_b = pwm_req; req_a = REQ_LO; end
                SECTOR_4: begin req_c = pwm_req; req_a = REQ_LO; end
                SECTOR_5: begin req_c = pwm_req; req_b = REQ_LO; end
                default: ;
            endcase
        end
    end

    motoro3_leg_deadtime #(.DT_W(DT_W)) u_leg_a (
        .clk          (clk),
        .rst          (rst),
        .req          (req_a),
        .m3r_deadTime (m3r_deadTime),
        .gateH        (gateAH),
        .gateL        (gateAL)
    );

    motoro3_leg_deadtime #(.DT_W(DT_W)) u_leg_b (
        .clk          (clk),
        .rst          (rst),
        .req          (req_b),
        .m3r_deadTime (m3r_deadTime),
        .gateH        (gateBH),
        .gateL        (gateBL)
    );

    motoro3_leg_deadtime #(.DT_W(DT_W)) u_leg_c (
        .clk          (clk),
        .rst          (rst),
        .req          (req_c),
        .m3r_deadTime (m3r_deadTime),
        .gateH        (gateCH),
        .gateL        (gateCL)
    );

    assign faultLatched = fault_q;
    assign sector       = sector_q;

endmodule

// File: tb/tb_motoro3_gate_driver.sv
// Scenario bench for motoro3_gate_driver: expectations are queued with each stimulus
// cycle and popped/compared one clock later against {gates, faultLatched, sector}.
module tb_motoro3_gate_driver;

    localparam int DT_W = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            pwm = 1'b0;
    logic [3:0]      sgStep = 4'd0;
    logic [DT_W-1:0] m3r_deadTime = '0;
    logic            m3r_gateEn = 1'b0;
    logic            m3r_faultClr = 1'b0;
    logic            faultIn = 1'b0;
    logic            gateAH, gateAL, gateBH, gateBL, gateCH, gateCL;
    logic            faultLatched;
    logic [2:0]      sector;

    int tests = 0;
    int fails = 0;
    bit run_done = 1'b0;

    typedef struct {
        string      name;
        logic [9:0] v;
    } exp_t;
    exp_t sb[$];
    exp_t e;

    motoro3_gate_driver #(.DT_W(DT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .pwm          (pwm),
        .sgStep       (sgStep),
        .m3r_deadTime (m3r_deadTime),
        .m3r_gateEn   (m3r_gateEn),
        .m3r_faultClr (m3r_faultClr),
        .faultIn      (faultIn),
        .gateAH       (gateAH),
        .gateAL       (gateAL),
        .gateBH       (gateBH),
        .gateBL       (gateBL),
        .gateCH       (gateCH),
        .gateCL       (gateCL),
        .faultLatched (faultLatched),
        .sector       (sector)
    );

    always #50 clk = ~clk;

    // No leg may ever drive both of its gates.
    always @(negedge clk) begin
        if (!run_done && ((gateAH && gateAL) || (gateBH && gateBL) || (gateCH && gateCL))) begin
            fails++;
            $display("FAIL overlap: gates=%b required no H/L pair high", obs());
        end
    end

    function automatic logic [9:0] obs();
        return {gateAH, gateAL, gateBH, gateBL, gateCH, gateCL, faultLatched, sector};
    endfunction

    function automatic logic [9:0] expv(input logic [5:0] g, input logic flt, input logic [2:0] sec);
        return {g, flt, sec};
    endfunction

    task automatic push(input string name, input logic [9:0] v);
        exp_t x;
        x.name = name;
        x.v    = v;
        sb.push_back(x);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; pwm = 1'b1; sgStep = 4'd1; m3r_gateEn = 1'b1; m3r_deadTime = 8'd0;
        for (int k = 0; k < 2; k++) begin
            push("reset_hold", expv(6'b000000, 1'b0, 3'd7));
            step();
            e = sb.pop_front(); tests++;
            if (obs() !== e.v) begin
                fails++; $display("FAIL %s: got %b want %b", e.name, obs(), e.v);
            end
        end
        rst = 1'b0;
        push("reset_release", expv(6'b100100, 1'b0, 3'd0));
        step();
        e = sb.pop_front(); tests++;
        if (obs() !== e.v) begin
            fails++; $display("FAIL %s: got %b want %b", e.name, obs(), e.v);
        end
    endtask

    task automatic test_pwm_deadtime();
        m3r_deadTime = 8'd10;
        pwm = 1'b0;
        for (int k = 1; k <= 13; k++) begin
            if (k == 3) pwm = 1'b1;
            push($sformatf("pwm_dt_k%0d", k), expv({(k >= 12), 5'b00100}, 1'b0, 3'd0));
            step();
            e = sb.pop_front(); tests++;
            if (obs() !== e.v) begin
                fails++; $display("FAIL %s: got %b want %b", e.name, obs(), e.v);
            end
        end
    endtask

    task automatic test_sector_change();
        m3r_deadTime = 8'd5;
        sgStep = 4'd7;
        for (int k = 1; k <= 8; k++) begin
            push($sformatf("sector_k%0d", k),
                 expv((k >= 7) ? 6'b011000 : 6'b000000, 1'b0, 3'd3));
            step();
            e = sb.pop_front(); tests++;
            if (obs() !== e.v) begin
                fails++; $display("FAIL %s: got %b want %b", e.name, obs(), e.v);
            end
        end
    endtask

    task automatic test_fault();
        logic       fin [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic       clr [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic       flt [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [5:0] g   [7] = '{6'b0, 6'b0, 6'b0, 6'b0, 6'b0, 6'b0, 6'b011000};
        for (int k = 0; k < 7; k++) begin
            faultIn = fin[k];
            m3r_faultClr = clr[k];
            push($sformatf("fault_f%0d", k), expv(g[k], flt[k], 3'd3));
            step();
            e = sb.pop_front(); tests++;
            if (obs() !== e.v) begin
                fails++; $display("FAIL %s: got %b want %b", e.name, obs(), e.v);
            end
        end
    endtask

    task automatic test_coast_enable();
        logic [3:0] stp [7] = '{4'd0, 4'd15, 4'd3, 4'd3, 4'd3, 4'd3, 4'd3};
        logic       en  [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [2:0] sec [7] = '{3'd7, 3'd7, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1};
        logic [5:0] g   [7] = '{6'b0, 6'b0, 6'b0, 6'b000001, 6'b000001, 6'b000001, 6'b100001};
        for (int k = 0; k < 7; k++) begin
            sgStep = stp[k];
            m3r_gateEn = en[k];
            push($sformatf("coast_en_c%0d", k), expv(g[k], 1'b0, sec[k]));
            step();
            e = sb.pop_front(); tests++;
            if (obs() !== e.v) begin
                fails++; $display("FAIL %s: got %b want %b", e.name, obs(), e.v);
            end
        end
    endtask

    task automatic test_deadtime_reg();
        m3r_deadTime = 8'd20;
        pwm = 1'b0;
        for (int k = 1; k <= 22; k++) begin
            if (k == 2) begin
                m3r_deadTime = 8'd2;
                pwm = 1'b1;
            end
            push($sformatf("dtreg20_k%0d", k), expv({(k >= 22), 5'b00001}, 1'b0, 3'd1));
            step();
            e = sb.pop_front(); tests++;
            if (obs() !== e.v) begin
                fails++; $display("FAIL %s: got %b want %b", e.name, obs(), e.v);
            end
        end
        pwm = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            if (k == 2) pwm = 1'b1;
            push($sformatf("dtreg2_k%0d", k), expv({(k >= 4), 5'b00001}, 1'b0, 3'd1));
            step();
            e = sb.pop_front(); tests++;
            if (obs() !== e.v) begin
                fails++; $display("FAIL %s: got %b want %b", e.name, obs(), e.v);
            end
        end
    endtask

    task automatic test_midrun_reset();
        logic       fin [3] = '{1'b1, 1'b0, 1'b0};
        logic       rs  [3] = '{1'b0, 1'b1, 1'b0};
        logic [9:0] ex  [3];
        ex[0] = expv(6'b000000, 1'b1, 3'd1);
        ex[1] = expv(6'b000000, 1'b0, 3'd7);
        ex[2] = expv(6'b100001, 1'b0, 3'd1);
        for (int k = 0; k < 3; k++) begin
            faultIn = fin[k];
            rst = rs[k];
            push($sformatf("midrst_r%0d", k), ex[k]);
            step();
            e = sb.pop_front(); tests++;
            if (obs() !== e.v) begin
                fails++; $display("FAIL %s: got %b want %b", e.name, obs(), e.v);
            end
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_pwm_deadtime();
        test_sector_change();
        test_fault();
        test_coast_enable();
        test_deadtime_reg();
        test_midrun_reset();
        run_done = 1'b1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
